// File: rtl/vector_regfile_pkg.sv
// Shared types and widths for the vector register file.
package vec_pkg;
  localparam int LANE_W     = 32;
  localparam int LANES      = 4;
  localparam int VEC_W      = LANES * LANE_W;
  localparam int LANE_IDX_W = 2;

  typedef logic [VEC_W-1:0]      vec_t;
  typedef logic [LANE_W-1:0]     lane_t;
  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  typedef enum logic {WR_FULL = 1'b0, WR_LANE = 1'b1} wmode_e;
  typedef enum logic {RF_IDLE = 1'b0, RF_CLEAR = 1'b1} rf_state_e;
endpackage

// File: rtl/vector_regfile_if.sv
// Read/write/clear bus of the vector register file.
interface vector_regfile_if #(parameter int ADDR_W = 4);
  import vec_pkg::*;

  logic [ADDR_W-1:0] ra1, ra2, wa;
  vec_t              rd1, rd2, wd;
  logic              we;
  wmode_e            wmode;
  lane_idx_t         wlane;
  lane_t             ws;
  logic              wack;
  logic              clr;
  logic              busy;
  logic              done;

  modport master (output ra1, ra2, we, wa, wmode, wlane, wd, ws, clr,
                  input  rd1, rd2, wack, busy, done);
  modport slave  (input  ra1, ra2, we, wa, wmode, wlane, wd, ws, clr,
                  output rd1, rd2, wack, busy, done);
endinterface

// File: rtl/vector_regfile_lane_merge.sv
// Builds the post-write vector: full replace, or one lane replaced by a scalar.
// Shared by the commit path and the read bypass so both always agree.
module vreg_lane_merge
  import vec_pkg::*;
(
  input  vec_t      old_v,
  input  wmode_e    wmode,
  input  lane_idx_t wlane,
  input  vec_t      wd,
  input  lane_t     ws,
  output vec_t      merged
);
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign merged[k*LANE_W +: LANE_W] =
      (wmode == WR_FULL)           ? wd[k*LANE_W +: LANE_W] :
      (wlane == lane_idx_t'(k))    ? ws                     :
                                     old_v[k*LANE_W +: LANE_W];
  end
endmodule

// File: rtl/vector_regfile.sv
// Vector register file: 2 comb read ports with write bypass, 1 write port
// (full or lane insert), and a one-register-per-cycle clear sequencer.
module vector_regfile
  import vec_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input logic             clk,
  input logic             rst,
  vector_regfile_if.slave bus
);
  localparam logic [ADDR_W:0]   NREGS_W = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(NUM_REGS - 1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  vec_t              regs_q [NUM_REGS];
  vec_t              regs_d [NUM_REGS];

  vec_t old_w, wval, rd1_raw, rd2_raw;
  logic wr_hit;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < NREGS_W;
  endfunction

  // Writes are only taken while the sequencer is idle; out-of-range ones are acked but dropped.
  assign bus.wack = bus.we && (state_q == RF_IDLE);
  assign wr_hit   = bus.wack && in_range(bus.wa);
  assign old_w    = in_range(bus.wa) ? regs_q[bus.wa] : '0;

  vreg_lane_merge u_merge (
    .old_v  (old_w),
    .wmode  (bus.wmode),
    .wlane  (bus.wlane),
    .wd     (bus.wd),
    .ws     (bus.ws),
    .merged (wval)
  );

  assign rd1_raw  = in_range(bus.ra1) ? regs_q[bus.ra1] : '0;
  assign rd2_raw  = in_range(bus.ra2) ? regs_q[bus.ra2] : '0;
  assign bus.rd1  = (wr_hit && bus.ra1 == bus.wa) ? wval : rd1_raw;
  assign bus.rd2  = (wr_hit && bus.ra2 == bus.wa) ? wval : rd2_raw;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  // Next register contents: accepted write, then the clear of the current counter slot.
  always_comb begin
    regs_d = regs_q;
    if (wr_hit)              regs_d[bus.wa] = wval;
    if (state_q == RF_CLEAR) regs_d[cnt_q]  = '0;
  end

  // Sequencer next state: one register per cycle, done pulse after the last.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      RF_IDLE: begin
        if (bus.clr) begin
          state_d = RF_CLEAR;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      RF_CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = RF_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RF_IDLE;
    endcase
  end

  // State, outputs and register array; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      regs_q  <= regs_d;
    end
  end
endmodule

// File: tb/tb_vector_regfile.sv
// Scoreboard bench: two instances (16 and 12 registers) driven with identical
// stimulus; expectations come from an array-based model of the register file.
module tb_vector_regfile;
  import vec_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vector_regfile_if #(.ADDR_W(4)) bus16 ();
  vector_regfile_if #(.ADDR_W(4)) bus12 ();

  vector_regfile #(.NUM_REGS(16), .ADDR_W(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  vector_regfile #(.NUM_REGS(12), .ADDR_W(4)) dut12 (.clk(clk), .rst(rst), .bus(bus12.slave));

  typedef struct {
    logic [1:0][127:0] rd1, rd2;
    logic [1:0]        wack, busy, done;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: per instance register contents and clear progress.
  int           nregs [2] = '{16, 12};
  logic [127:0] mem   [2][16];
  int           clr_pos [2];   // 0 = not clearing, else 1-based index of next reg to zero
  bit           done_m  [2];

  logic [1:0][127:0] a_rd1, a_rd2;
  logic [1:0]        a_wack, a_busy, a_done;
  assign a_rd1  = {bus12.rd1,  bus16.rd1};
  assign a_rd2  = {bus12.rd2,  bus16.rd2};
  assign a_wack = {bus12.wack, bus16.wack};
  assign a_busy = {bus12.busy, bus16.busy};
  assign a_done = {bus12.done, bus16.done};

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 16; a++) mem[d][a] = '0;
      clr_pos[d] = 0;
      done_m[d]  = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, nregs[d], $time, act, exp);
    end
  endtask

  // Monitor: outputs are settled mid-cycle; pop one expectation per cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int d = 0; d < 2; d++) begin
        chk("rd1",  d, a_rd1[d],  e.rd1[d]);
        chk("rd2",  d, a_rd2[d],  e.rd2[d]);
        chk("wack", d, 128'(a_wack[d]), 128'(e.wack[d]));
        chk("busy", d, 128'(a_busy[d]), 128'(e.busy[d]));
        chk("done", d, 128'(a_done[d]), 128'(e.done[d]));
      end
    end
  end

  // One cycle of stimulus; called just after a posedge.
  task automatic drive(input bit we, input logic [3:0] wa, input bit wm, input logic [1:0] wl,
                       input logic [127:0] wd, input logic [31:0] ws, input bit clr,
                       input logic [3:0] ra1, input logic [3:0] ra2,
                       input bit rst_lvl, input bit rst_mid);
    exp_t         e;
    bit           wk [2];
    logic [127:0] nv;
    rst = rst_lvl;
    if (rst_lvl) model_reset();
    bus16.we = we; bus16.wa = wa; bus16.wmode = wmode_e'(wm); bus16.wlane = wl;
    bus16.wd = wd; bus16.ws = ws; bus16.clr = clr; bus16.ra1 = ra1; bus16.ra2 = ra2;
    bus12.we = we; bus12.wa = wa; bus12.wmode = wmode_e'(wm); bus12.wlane = wl;
    bus12.wd = wd; bus12.ws = ws; bus12.clr = clr; bus12.ra1 = ra1; bus12.ra2 = ra2;
    if (rst_mid) begin
      #1;
      rst = 1'b1;
      model_reset();
    end
    for (int d = 0; d < 2; d++) begin
      wk[d] = we && (clr_pos[d] == 0);
      nv = (wa < nregs[d]) ? mem[d][wa] : '0;
      if (wm) nv[wl*32 +: 32] = ws; else nv = wd;
      e.wack[d] = wk[d];
      e.busy[d] = (clr_pos[d] != 0);
      e.done[d] = done_m[d];
      e.rd1[d]  = (wk[d] && wa < nregs[d] && ra1 == wa) ? nv : (ra1 < nregs[d]) ? mem[d][ra1] : '0;
      e.rd2[d]  = (wk[d] && wa < nregs[d] && ra2 == wa) ? nv : (ra2 < nregs[d]) ? mem[d][ra2] : '0;
      if (wk[d] && wa < nregs[d]) mem[d][wa] = nv;   // takes effect at the coming edge
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else begin
      for (int d = 0; d < 2; d++) begin
        done_m[d] = 1'b0;
        if (clr_pos[d] != 0) begin
          mem[d][clr_pos[d]-1] = '0;
          clr_pos[d]++;
          if (clr_pos[d] > nregs[d]) begin
            clr_pos[d] = 0;
            done_m[d]  = 1'b1;
          end
        end else if (clr) begin
          clr_pos[d] = 1;
        end
      end
    end
  endtask

  task automatic rd(input logic [3:0] a1, input logic [3:0] a2);
    drive(0, 4'd0, 0, 2'd0, 128'h0, 32'h0, 0, a1, a2, 0, 0);
  endtask

  task automatic wr(input logic [3:0] wa, input bit wm, input logic [1:0] wl,
                    input logic [127:0] wd, input logic [31:0] ws, input logic [3:0] a1, input logic [3:0] a2);
    drive(1, wa, wm, wl, wd, ws, 0, a1, a2, 0, 0);
  endtask

  function automatic logic [127:0] rv();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic rd_all();
    for (int a = 0; a < 16; a++) rd(4'(a), 4'(15 - a));
  endtask

  initial begin
    logic [127:0] v3;
    model_reset();
    drive(0, 4'd0, 0, 2'd0, 128'h0, 32'h0, 0, 4'd0, 4'd0, 1, 0);
    @(posedge clk); #1;
    exp_q.delete();
    drive(0, 4'd0, 0, 2'd0, 128'h0, 32'h0, 0, 4'd0, 4'd1, 1, 0);
    drive(0, 4'd0, 0, 2'd0, 128'h0, 32'h0, 0, 4'd2, 4'd3, 1, 0);

    // Reset contents
    rd_all();

    // Full write with same-cycle bypass, then plain read
    v3 = 128'h000FF000_01020304_0000AAAA_DEADBEEF;
    wr(4'd3, 0, 2'd0, v3, 32'h0, 4'd3, 4'd3);
    rd(4'd3, 4'd2);

    // Lane inserts of 458 into each lane of r3
    for (int l = 0; l < 4; l++) begin
      wr(4'd3, 1, 2'(l), rv(), 32'd458, 4'd3, 4'd4);
      rd(4'd3, 4'd3);
    end

    // Clear with a simultaneous write to r5, random traffic while busy
    wr(4'd5, 0, 2'd0, rv(), 32'h0, 4'd5, 4'd0);
    wr(4'd6, 0, 2'd0, rv(), 32'h0, 4'd6, 4'd6);
    drive(1, 4'd5, 0, 2'd0, rv(), 32'h0, 1, 4'd5, 4'd6, 0, 0);
    for (int i = 0; i < 18; i++)
      drive($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
            rv(), $urandom, 0, 4'($urandom_range(0, 15)), 4'(i % 16), 0, 0);
    rd_all();

    // Reset during the fifth clear cycle
    for (int a = 0; a < 4; a++) wr(4'(a * 3), 0, 2'd0, rv(), 32'h0, 4'(a * 3), 4'd0);
    drive(0, 4'd0, 0, 2'd0, 128'h0, 32'h0, 1, 4'd0, 4'd3, 0, 0);
    for (int i = 0; i < 4; i++) rd(4'd3, 4'd9);
    drive(0, 4'd0, 0, 2'd0, 128'h0, 32'h0, 0, 4'd3, 4'd6, 0, 1);
    rd_all();
    wr(4'd7, 0, 2'd0, rv(), 32'h0, 4'd7, 4'd0);
    rd(4'd7, 4'd0);

    // Writes beyond the 12-register instance
    wr(4'd2, 0, 2'd0, rv(), 32'h0, 4'd2, 4'd2);
    wr(4'd15, 0, 2'd0, rv(), 32'h0, 4'd15, 4'd2);
    wr(4'd13, 1, 2'd1, 128'h0, $urandom, 4'd13, 4'd15);
    rd_all();

    // Random traffic
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
            rv(), $urandom, ($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 0, 0);
    rd_all();

    @(negedge clk); #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
